// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU background fetch path.
// Holds the 8-step fetch phase enum, the VRAM region bases and the
// attribute-quadrant shift helper used by the fetcher.
package ppu_pkg;

  // One tile fetch takes eight clocks: address/data pairs for NT, AT, PT-lo, PT-hi.
  typedef enum logic [2:0] {
    PH_NT_A  = 3'd0,
    PH_NT_D  = 3'd1,
    PH_AT_A  = 3'd2,
    PH_AT_D  = 3'd3,
    PH_PTL_A = 3'd4,
    PH_PTL_D = 3'd5,
    PH_PTH_A = 3'd6,
    PH_PTH_D = 3'd7
  } fetch_phase_t;

  localparam logic [15:0] NT_BASE   = 16'h2000;
  localparam logic [15:0] AT_BASE   = 16'h23C0;
  localparam logic [15:0] PT_HI_OFS = 16'd8;

  // Each attribute byte covers a 4x4 tile block; the 2x2 quadrant picks the bit pair.
  function automatic logic [2:0] at_shift(input logic [4:0] cy, input logic [4:0] cx);
    return {cy[1], cx[1], 1'b0};
  endfunction

endpackage

// File: rtl/ppu_bg_fetcher_shift.sv
// bg_shift_reg: 16-bit pattern lo/hi shift pair for the background pipeline.
// Ports: clk/rst_n, shift_en (shift left by 1), load (replace low byte while
// shifting), lo_in/hi_in (new tile bytes), tap (fine x), bits ({hi,lo} tap output).
module bg_shift_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       load,
  input  logic [7:0] lo_in,
  input  logic [7:0] hi_in,
  input  logic [2:0] tap,
  output logic [1:0] bits
);

  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic [3:0]  tap_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (shift_en) begin
      // A load happens on the same edge as a shift: upper byte takes the
      // shifted bits, the low byte is replaced by the freshly fetched tile.
      if (load) begin
        lo_q <= {lo_q[14:7], lo_in};
        hi_q <= {hi_q[14:7], hi_in};
      end else begin
        lo_q <= {lo_q[14:0], 1'b0};
        hi_q <= {hi_q[14:0], 1'b0};
      end
    end
  end

  assign tap_idx = 4'd15 - {1'b0, tap};
  assign bits    = {hi_q[tap_idx], lo_q[tap_idx]};

endmodule

// File: rtl/ppu_bg_fetcher.sv
// ppu_bg_fetcher: background tile fetcher feeding the PPU pixel mux.
// Ports: render/line control, scroll inputs (coarse/fine x/y, nametable, pattern
// table), registered VRAM read port (vram_addr/vram_rd/vram_data, latency 1),
// and per-clock pixel/palette/pixel_valid output.
module ppu_bg_fetcher
  import ppu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              render_en,
  input  logic              line_start,
  input  logic [4:0]        coarse_x_init,
  input  logic [4:0]        coarse_y,
  input  logic [2:0]        fine_y,
  input  logic [2:0]        fine_x,
  input  logic [1:0]        nt_sel,
  input  logic              bg_table_sel,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [7:0]        vram_data,
  output logic [1:0]        pixel,
  output logic [1:0]        palette,
  output logic              pixel_valid
);

  fetch_phase_t phase_q, phase_eff, phase_nxt;

  logic [4:0]  cx_q, cx_eff;
  logic [1:0]  nt_q, nt_eff;
  logic [7:0]  tile_q;
  logic [7:0]  pt_lo_q;
  logic [1:0]  attr_sel_q;
  logic [1:0]  attr_latch_q;
  logic [7:0]  at_lo_q, at_hi_q;
  logic [1:0]  tile_cnt_q;
  logic [ADDR_W-1:0] vram_addr_q;
  logic        vram_rd_q;

  logic        issue;
  logic [15:0] addr_nxt;
  logic [15:0] ptl_addr;
  logic        cap_tile, cap_attr, cap_ptlo, load_tile;

  // The line_start cycle itself acts as phase 0 using the newly loaded column
  // and nametable, so the NT address is issued on that same edge and any
  // in-progress fetch is abandoned.
  assign phase_eff = line_start ? PH_NT_A : phase_q;
  assign cx_eff    = line_start ? coarse_x_init : cx_q;
  assign nt_eff    = line_start ? nt_sel : nt_q;

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_NT_A;
    end else begin
      phase_q <= phase_nxt;
    end
  end

  // Next phase: advance only while rendering.
  always_comb begin
    phase_nxt = phase_eff;
    if (render_en) begin
      phase_nxt = fetch_phase_t'(3'(phase_eff + 3'd1));
    end
  end

  assign ptl_addr = {3'b000, bg_table_sel, tile_q, 1'b0, fine_y};

  // Phase decode: which address to issue and which byte to capture.
  always_comb begin
    issue     = 1'b0;
    addr_nxt  = '0;
    cap_tile  = 1'b0;
    cap_attr  = 1'b0;
    cap_ptlo  = 1'b0;
    load_tile = 1'b0;
    if (render_en) begin
      unique case (phase_eff)
        PH_NT_A: begin
          issue    = 1'b1;
          addr_nxt = NT_BASE | {4'b0, nt_eff, 10'b0} | {6'b0, coarse_y, 5'b0}
                     | {11'b0, cx_eff};
        end
        PH_NT_D:  cap_tile = 1'b1;
        PH_AT_A: begin
          issue    = 1'b1;
          addr_nxt = AT_BASE | {4'b0, nt_eff, 10'b0} | {10'b0, coarse_y[4:2], 3'b0}
                     | {13'b0, cx_eff[4:2]};
        end
        PH_AT_D:  cap_attr = 1'b1;
        PH_PTL_A: begin
          issue    = 1'b1;
          addr_nxt = ptl_addr;
        end
        PH_PTL_D: cap_ptlo = 1'b1;
        PH_PTH_A: begin
          issue    = 1'b1;
          addr_nxt = ptl_addr + PT_HI_OFS;
        end
        PH_PTH_D: load_tile = 1'b1;
        default: ;
      endcase
    end
  end

  // Fetch datapath, scroll counters and attribute shifters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q         <= '0;
      nt_q         <= '0;
      tile_q       <= '0;
      pt_lo_q      <= '0;
      attr_sel_q   <= '0;
      attr_latch_q <= '0;
      at_lo_q      <= '0;
      at_hi_q      <= '0;
      tile_cnt_q   <= '0;
      vram_addr_q  <= '0;
      vram_rd_q    <= 1'b0;
    end else begin
      if (line_start) begin
        cx_q       <= coarse_x_init;
        nt_q       <= nt_sel;
        tile_cnt_q <= '0;
      end else if (load_tile) begin
        cx_q <= cx_q + 5'd1;
        if (cx_q == 5'd31) begin
          nt_q[0] <= ~nt_q[0];
        end
        if (tile_cnt_q != 2'd2) begin
          tile_cnt_q <= tile_cnt_q + 2'd1;
        end
      end

      if (issue) begin
        vram_addr_q <= ADDR_W'(addr_nxt);
      end
      vram_rd_q <= issue;

      if (cap_tile) begin
        tile_q <= vram_data;
      end
      if (cap_attr) begin
        attr_sel_q <= 2'(vram_data >> at_shift(coarse_y, cx_eff));
      end
      if (cap_ptlo) begin
        pt_lo_q <= vram_data;
      end
      if (load_tile) begin
        attr_latch_q <= attr_sel_q;
      end

      // Attribute shifters refill one bit per clock from the latch, which
      // keeps them aligned with the pattern bits of the same tile.
      if (render_en) begin
        at_lo_q <= {at_lo_q[6:0], attr_latch_q[0]};
        at_hi_q <= {at_hi_q[6:0], attr_latch_q[1]};
      end
    end
  end

  bg_shift_reg u_pat (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (render_en),
    .load     (load_tile),
    .lo_in    (pt_lo_q),
    .hi_in    (vram_data),
    .tap      (fine_x),
    .bits     (pixel)
  );

  assign palette     = {at_hi_q[3'd7 - fine_x], at_lo_q[3'd7 - fine_x]};
  assign pixel_valid = (tile_cnt_q == 2'd2);
  assign vram_addr   = vram_addr_q;
  assign vram_rd     = vram_rd_q;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        render_en;
  logic        line_start;
  logic [4:0]  coarse_x_init;
  logic [4:0]  coarse_y;
  logic [2:0]  fine_y;
  logic [2:0]  fine_x;
  logic [1:0]  nt_sel;
  logic        bg_table_sel;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data = 8'h00;
  logic [1:0]  pixel;
  logic [1:0]  palette;
  logic        pixel_valid;

  ppu_bg_fetcher #(.ADDR_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .render_en     (render_en),
    .line_start    (line_start),
    .coarse_x_init (coarse_x_init),
    .coarse_y      (coarse_y),
    .fine_y        (fine_y),
    .fine_x        (fine_x),
    .nt_sel        (nt_sel),
    .bg_table_sel  (bg_table_sel),
    .vram_addr     (vram_addr),
    .vram_rd       (vram_rd),
    .vram_data     (vram_data),
    .pixel         (pixel),
    .palette       (palette),
    .pixel_valid   (pixel_valid)
  );

  always #5 clk = ~clk;

  // VRAM model: read data follows the address on the falling edge.
  logic [7:0] mem [0:65535];
  always @(negedge clk) vram_data = mem[vram_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (tile-level view) ----------------
  int   n;            // enabled clocks since line_start
  bit   in_line;
  bit   addr_known;
  int   exp_addr;
  int   cx0, nt0, cy, fy, sel, fx;

  function automatic int t_cx(int t);  return (cx0 + t) % 32; endfunction
  function automatic int t_nt(int t);  return nt0 ^ (((cx0 + t) / 32) % 2); endfunction
  function automatic int nt_addr(int t);
    return 'h2000 + t_nt(t) * 1024 + cy * 32 + t_cx(t);
  endfunction
  function automatic int at_addr(int t);
    return 'h23C0 + t_nt(t) * 1024 + (cy / 4) * 8 + t_cx(t) / 4;
  endfunction
  function automatic int ptlo_addr(int t);
    return sel * 4096 + int'(mem[nt_addr(t)]) * 16 + fy;
  endfunction
  function automatic int attr_of(int t);
    int sh;
    sh = ((cy / 2) % 2) * 4 + ((t_cx(t) / 2) % 2) * 2;
    return (int'(mem[at_addr(t)]) >> sh) % 4;
  endfunction
  // Pixel p of the line's background stream (p counts from first tile, bit 7).
  function automatic int pix_of(int p);
    int t, b;
    t = p / 8;
    b = 7 - (p % 8);
    return ((int'(mem[ptlo_addr(t) + 8]) >> b) % 2) * 2 + ((int'(mem[ptlo_addr(t)]) >> b) % 2);
  endfunction

  task automatic cyc(input bit ls, input bit en);
    int ph, t, p;
    bit exp_rd;
    line_start = ls;
    render_en  = en;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    if (ls) begin
      in_line = 1'b1;
      n   = 0;
      cx0 = int'(coarse_x_init);
      nt0 = int'(nt_sel);
      cy  = int'(coarse_y);
      fy  = int'(fine_y);
      sel = int'(bg_table_sel);
      fx  = int'(fine_x);
    end
    if (en && !in_line) addr_known = 1'b0;
    exp_rd = 1'b0;
    if (in_line && en) begin
      ph = n % 8;
      t  = n / 8;
      case (ph)
        0: exp_addr = nt_addr(t);
        2: exp_addr = at_addr(t);
        4: exp_addr = ptlo_addr(t);
        6: exp_addr = ptlo_addr(t) + 8;
        default: ;
      endcase
      if (ph % 2 == 0) begin
        exp_rd = 1'b1;
        addr_known = 1'b1;
      end
      n++;
    end
    if (in_line) begin
      chk("vram_rd", vram_rd, exp_rd);
      if (addr_known) chk("vram_addr", vram_addr, exp_addr);
      chk("pixel_valid", pixel_valid, n >= 16);
      if (n >= 16) begin
        p = n - 16 + fx;
        chk("pixel", pixel, pix_of(p));
        chk("palette", palette, attr_of(p / 8));
      end
    end
  endtask

  task automatic start_line(input int cx_i, input int cy_i, input int nt_i,
                            input int fy_i, input int sel_i, input int fx_i, input bit en);
    coarse_x_init = 5'(cx_i);
    coarse_y      = 5'(cy_i);
    nt_sel        = 2'(nt_i);
    fine_y        = 3'(fy_i);
    bg_table_sel  = 1'(sel_i);
    fine_x        = 3'(fx_i);
    cyc(1'b1, en);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 'h3000; a++) mem[a] = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".vram_addr"}, vram_addr, 0);
    chk({tag, ".vram_rd"}, vram_rd, 0);
    chk({tag, ".pixel"}, pixel, 0);
    chk({tag, ".palette"}, palette, 0);
    chk({tag, ".pixel_valid"}, pixel_valid, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int cx0, cy, nt, fy, sel;
    int exp_nt0, exp_at0, exp_nt1, exp_pal0;
  } vec_t;

  vec_t vt [5];
  int   first_pix [8];

  initial begin
    logic [1:0] hold_pix, hold_pal;
    logic [15:0] hold_addr;
    int ptl;

    vt[0] = '{0,  0,  0, 0, 0, 'h2000, 'h23C0, 'h2001, 0};
    vt[1] = '{31, 0,  0, 3, 1, 'h201F, 'h23C7, 'h2400, 1};
    vt[2] = '{2,  2,  0, 0, 0, 'h2042, 'h23C0, 'h2043, 3};
    vt[3] = '{5,  9,  3, 7, 0, 'h2D25, 'h2FD1, 'h2D26, 0};
    vt[4] = '{31, 30, 1, 2, 1, 'h27DF, 'h27FF, 'h23C0, 3};
    // lo=0xF0, hi=0xAA, pixel={hi,lo} from bit 7 down
    first_pix = '{3, 1, 3, 1, 2, 0, 2, 0};

    in_line = 1'b0; addr_known = 1'b1; exp_addr = 0; n = 0;
    cx0 = 0; nt0 = 0; cy = 0; fy = 0; sel = 0; fx = 0;
    line_start = 1'b0; render_en = 1'b1;
    coarse_x_init = '0; coarse_y = '0; fine_y = '0; fine_x = '0;
    nt_sel = '0; bg_table_sel = 1'b0;
    fill_mem();

    rst_n = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed lines with hand-computed addresses, pixels and palette.
    for (int v = 0; v < 5; v++) begin
      fill_mem();
      mem[vt[v].exp_nt0] = 8'h01;
      mem[vt[v].exp_at0] = 8'hE4;
      ptl = vt[v].sel * 4096 + 'h10 + vt[v].fy;
      mem[ptl]     = 8'hF0;
      mem[ptl + 8] = 8'hAA;
      start_line(vt[v].cx0, vt[v].cy, vt[v].nt, vt[v].fy, vt[v].sel, 0, 1'b1);
      chk("tbl.nt0", vram_addr, vt[v].exp_nt0);
      for (int c = 0; c < 26; c++) begin
        cyc(1'b0, 1'b1);
        if (n == 3)  chk("tbl.at0", vram_addr, vt[v].exp_at0);
        if (n == 9)  chk("tbl.nt1", vram_addr, vt[v].exp_nt1);
        if (n == 15) chk("tbl.valid_lo", pixel_valid, 0);
        if (n >= 16 && n < 24) begin
          chk("tbl.pixel", pixel, first_pix[n - 16]);
          chk("tbl.palette", palette, vt[v].exp_pal0);
        end
      end
    end

    // Render stall mid-tile: outputs freeze, fetch resumes where it stopped.
    fill_mem();
    start_line(7, 13, 2, 5, 1, 0, 1'b1);
    for (int c = 0; c < 20; c++) cyc(1'b0, 1'b1);
    hold_pix = pixel; hold_pal = palette; hold_addr = vram_addr;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 1'b0);
      chk("stall.rd", vram_rd, 0);
      chk("stall.pixel", pixel, hold_pix);
      chk("stall.palette", palette, hold_pal);
      chk("stall.addr", vram_addr, hold_addr);
    end
    for (int c = 0; c < 30; c++) cyc(1'b0, 1'b1);

    // Reset mid-fetch at phase 5, then restart with fine_x = 3.
    for (int i = 0; i < 16 && (n % 8) != 5; i++) cyc(1'b0, 1'b1);
    chk("rst.phase_reached", n % 8, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    in_line = 1'b0; addr_known = 1'b1; exp_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    rst_n = 1'b1;
    fill_mem();
    start_line(12, 6, 1, 4, 0, 3, 1'b1);
    for (int c = 0; c < 60; c++) cyc(1'b0, 1'b1);

    // Randomized lines: random scroll, stalls and mid-tile restarts.
    for (int l = 0; l < 8; l++) begin
      fill_mem();
      start_line($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                 ($urandom_range(0, 3) != 0));
      for (int c = 0, len = $urandom_range(60, 140); c < len; c++)
        cyc(1'b0, ($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
